diag_skewer: RTL and testbench
==============================

// Module: diag_skewer
// PURPOSE
//  Takes one 4x4 matrix and streams it out as skewed anti-diagonals on four lanes,
//  one diagonal per beat, 7 beats per matrix. It is the transmit-side inverse of
//  the aggregator, which collects skewed lanes back into a 4x4 matrix.
//  Lane stream from one matrix, fed to the aggregator, rebuilds the same matrix.
// PARAMETERS
//  WIDTH  32  bit width of one matrix element / one lane
// PORTS
//  clk        in   1          single clock, all state updates on posedge
//  rst_n      in   1          synchronous reset, active-low
//  in_valid   in   1          mat holds a matrix to be sent
//  in_ready   out  1          matrix accepted at posedge when in_valid && in_ready
//  mat        in   16*WIDTH   element (i,j), i,j=1..4, at [((i-1)*4+(j-1))*WIDTH +: WIDTH]
//  out_ready  in   1          downstream consumes current beat at posedge
//  out_valid  out  1          beat on d1..d4 is valid
//  lane_vld   out  4          lane k valid = bit k-1; 0001,0011,0111,1111,0111,0011,0001
//  d1..d4     out  WIDTH each lane data; 0 when the lane (or out_valid) is inactive
//  diag       out  3          current diagonal index 0..6
//  last       out  1          out_valid && diag==6
// BEHAVIOUR
//  Reset (rst_n==0 at posedge): state=IDLE, diag=0, held matrix=0 -> out_valid=0,
//   lane_vld=0, d1..d4=0, last=0. Reset mid-stream aborts; remaining beats dropped.
//  States: IDLE, EMIT. Matrix captured into an internal register on acceptance.
//  in_ready = (IDLE) || (EMIT && diag==6 && out_ready) -- combinational; back-to-back ok.
//  IDLE: on in_valid -> capture mat, diag<=0, go EMIT. out_valid first high next cycle
//   (1 cycle latency from acceptance to beat 0).
//  EMIT: out_valid=1. If out_ready: diag<6 -> diag<=diag+1; diag==6 -> if in_valid
//   capture new mat, diag<=0, stay EMIT; else go IDLE. If !out_ready: hold everything
//   (diag, data, lane_vld stable while stalled).
//  in_valid while in_ready==0: ignored, mat not sampled.
//  Beat mapping: s=diag+2; active rows i from max(1,s-4) to min(4,s-1); lane k carries
//   element (i0+k-1, s-(i0+k-1)), i0=max(1,s-4). E.g. diag 3: d1..d4 = m14,m23,m32,m41;
//   diag 4: d1..d3 = m24,m33,m42, d4=0.
//  d1..d4, lane_vld, last are combinational from held matrix + diag + state.
//  diag wraps only via reload to 0; never counts past 6.
//  Sustained throughput: one matrix per 7 cycles with in_valid and out_ready held high.
// TESTING
//  1 Reset: rst_n=0 two cycles -> out_valid=0, d1..d4=0, in_ready=1, diag=0.
//  2 Single matrix m(i,j)=(i-1)*4+(j-1), out_ready=1 -> beats d1:0,1,2,3,7,b,f;
//    d2:-,4,5,6,a,e; d3:-,-,8,9,d; d4:-,-,-,c; lane_vld as listed; last on beat 7 only.
//  3 Back-to-back: second matrix (values +0x10) held on in_valid -> in_ready pulses with
//    last; beat 0 of matrix 2 (d1=0x10) immediately follows beat 6 of matrix 1, no gap.
//  4 Stall: out_ready=0 for 3 cycles at diag 2 -> d1..d3=2,5,8 held, diag stays 2,
//    in_ready=0; resume gives diag 3 next.
//  5 Reset at diag 4 -> next cycle out_valid=0, IDLE; new matrix restarts at diag 0.
//  6 Loopback into aggregator: random matrices -> aggregator r11..r44 equal source mat.

Source files
------------

// File: rtl/diag_skewer.sv
// diag_skewer: streams a held 4x4 matrix out as seven skewed anti-diagonal beats on four lanes
module diag_skewer #(
  parameter int WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [16*WIDTH-1:0] mat,
  input  logic                out_ready,
  output logic                out_valid,
  output logic [3:0]          lane_vld,
  output logic [WIDTH-1:0]    d1,
  output logic [WIDTH-1:0]    d2,
  output logic [WIDTH-1:0]    d3,
  output logic [WIDTH-1:0]    d4,
  output logic [2:0]          diag,
  output logic                last
);
  logic                r_emit;
  logic [2:0]          r_diag;
  logic [16*WIDTH-1:0] r_mat;
  logic [WIDTH-1:0]    w_el [16];
  logic [WIDTH-1:0]    w_d [4];
  logic [2:0]          w_row0;
  logic [2:0]          w_cnt;
  logic                w_acc;
  // First row touched by the current anti-diagonal and how many lanes it fills
  assign w_row0    = (r_diag > 3'd3) ? r_diag - 3'd3 : 3'd0;
  assign w_cnt     = (r_diag > 3'd3) ? 3'd7 - r_diag : r_diag + 3'd1;
  assign in_ready  = !r_emit || (r_diag == 3'd6 && out_ready);
  assign w_acc     = in_valid && in_ready;
  assign out_valid = r_emit;
  assign diag      = r_diag;
  assign last      = r_emit && r_diag == 3'd6;
  assign d1        = w_d[0];
  assign d2        = w_d[1];
  assign d3        = w_d[2];
  assign d4        = w_d[3];
  for (genvar e = 0; e < 16; e++) begin : g_el
    assign w_el[e] = r_mat[e*WIDTH +: WIDTH];
  end
  // Lane k carries row (row0+k) and the column that keeps row+col on this diagonal
  for (genvar k = 0; k < 4; k++) begin : g_lane
    logic [2:0] w_r;
    logic [2:0] w_c;
    logic       w_act;
    assign w_r         = w_row0 + 3'(k);
    assign w_c         = r_diag - w_r;
    assign w_act       = r_emit && (3'(k) < w_cnt);
    assign lane_vld[k] = w_act;
    assign w_d[k]      = w_act ? w_el[{w_r[1:0], w_c[1:0]}] : '0;
  end
  // Capture on acceptance, advance the diagonal on each consumed beat, hold while stalled
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_emit <= 1'b0;
      r_diag <= 3'd0;
      r_mat  <= '0;
    end else if (w_acc) begin
      r_emit <= 1'b1;
      r_diag <= 3'd0;
      r_mat  <= mat;
    end else if (r_emit && out_ready) begin
      r_emit <= r_diag != 3'd6;
      r_diag <= (r_diag == 3'd6) ? 3'd0 : r_diag + 3'd1;
    end
  end
endmodule

// File: tb/tb_diag_skewer.sv
// tb_diag_skewer: directed checks of the anti-diagonal skewer plus a reassembly loopback
module tb_diag_skewer;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [511:0] mat = '0;
  logic         out_ready = 1'b1;
  logic         out_valid;
  logic [3:0]   lane_vld;
  logic [31:0]  d1, d2, d3, d4;
  logic [2:0]   diag;
  logic         last;
  int n_cmp = 0;
  int n_fail = 0;
  logic [31:0] t1 [7] = '{32'h0, 32'h1, 32'h2, 32'h3, 32'h7, 32'hb, 32'hf};
  logic [31:0] t2 [7] = '{32'h0, 32'h4, 32'h5, 32'h6, 32'ha, 32'he, 32'h0};
  logic [31:0] t3 [7] = '{32'h0, 32'h0, 32'h8, 32'h9, 32'hd, 32'h0, 32'h0};
  logic [31:0] t4 [7] = '{32'h0, 32'h0, 32'h0, 32'hc, 32'h0, 32'h0, 32'h0};
  logic [3:0]  tl [7] = '{4'h1, 4'h3, 4'h7, 4'hf, 4'h7, 4'h3, 4'h1};

  diag_skewer #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .mat(mat),
    .out_ready(out_ready), .out_valid(out_valid), .lane_vld(lane_vld),
    .d1(d1), .d2(d2), .d3(d3), .d4(d4), .diag(diag), .last(last)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] mk(input logic [31:0] off);
    logic [511:0] m;
    for (int e = 0; e < 16; e++) m[e*32 +: 32] = 32'(e) + off;
    return m;
  endfunction

  task automatic beat(input string tag, input int b, input logic [31:0] off);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_diag"}, 32'(diag), 32'(b));
    chk({tag, "_lv"}, 32'(lane_vld), 32'(tl[b]));
    chk({tag, "_d1"}, d1, tl[b][0] ? t1[b] + off : 32'h0);
    chk({tag, "_d2"}, d2, tl[b][1] ? t2[b] + off : 32'h0);
    chk({tag, "_d3"}, d3, tl[b][2] ? t3[b] + off : 32'h0);
    chk({tag, "_d4"}, d4, tl[b][3] ? t4[b] + off : 32'h0);
    chk({tag, "_last"}, 32'(last), 32'(b == 6));
  endtask

  initial begin
    logic [511:0] src, rec;
    int row, col, cyc;
    bit done;
    // Reset
    tick();
    tick();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_d", d1 | d2 | d3 | d4, 32'd0);
    chk("rst_lv", 32'(lane_vld), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_diag", 32'(diag), 32'd0);
    chk("rst_last", 32'(last), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("idle_valid", 32'(out_valid), 32'd0);
    // Single matrix
    mat = mk(32'h0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    mat = '0;
    for (int b = 0; b < 7; b++) begin
      beat("single", b, 32'h0);
      tick();
    end
    chk("single_done", 32'(out_valid), 32'd0);
    // Back-to-back
    mat = mk(32'h0);
    in_valid = 1'b1;
    tick();
    mat = mk(32'h10);
    for (int b = 0; b < 7; b++) begin
      beat("b2b_a", b, 32'h0);
      chk("b2b_ready", 32'(in_ready), 32'(b == 6));
      tick();
    end
    in_valid = 1'b0;
    mat = '0;
    for (int b = 0; b < 7; b++) begin
      beat("b2b_b", b, 32'h10);
      tick();
    end
    chk("b2b_done", 32'(out_valid), 32'd0);
    // Stall at diag 2
    mat = mk(32'h0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    beat("pre_stall", 2, 32'h0);
    out_ready = 1'b0;
    in_valid = 1'b1;
    mat = mk(32'h40);
    for (int s = 0; s < 3; s++) begin
      tick();
      chk("stall_diag", 32'(diag), 32'd2);
      chk("stall_d1", d1, 32'h2);
      chk("stall_d2", d2, 32'h5);
      chk("stall_d3", d3, 32'h8);
      chk("stall_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    beat("resume", 3, 32'h0);
    for (int b = 4; b < 7; b++) begin
      tick();
      beat("resume", b, 32'h0);
    end
    tick();
    chk("stall_done", 32'(out_valid), 32'd0);
    // Reset mid-stream at diag 4
    mat = mk(32'h0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    chk("pre_rst_diag", 32'(diag), 32'd4);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_diag", 32'(diag), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_d", d1 | d2 | d3 | d4, 32'd0);
    mat = mk(32'h20);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int b = 0; b < 7; b++) begin
      beat("restart", b, 32'h20);
      tick();
    end
    // Loopback reassembly with random matrices and random back-pressure
    for (int t = 0; t < 4; t++) begin
      for (int e = 0; e < 16; e++) src[e*32 +: 32] = $urandom;
      rec = '0;
      mat = src;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      done = 1'b0;
      cyc = 0;
      while (!done && cyc < 100) begin
        out_ready = 1'($urandom_range(0, 1));
        if (out_valid && out_ready) begin
          for (int k = 0; k < 4; k++) if (lane_vld[k]) begin
            row = (diag > 3'd3 ? int'(diag) - 3 : 0) + k;
            col = int'(diag) - row;
            case (k)
              0: rec[(row*4+col)*32 +: 32] = d1;
              1: rec[(row*4+col)*32 +: 32] = d2;
              2: rec[(row*4+col)*32 +: 32] = d3;
              default: rec[(row*4+col)*32 +: 32] = d4;
            endcase
          end
          done = last;
        end
        tick();
        cyc++;
      end
      out_ready = 1'b1;
      chk("loop_timeout", 32'(done), 32'd1);
      n_cmp++;
      assert (rec === src) else begin
        n_fail++;
        $error("FAIL loopback observed=%h expected=%h", rec, src);
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
